// File: rtl/cpu5_ifetch_pkg.sv
// Shared constants and helpers for the cpu5 instruction fetch unit.
// Defaults match the core-wide definitions.
package cpu5_ifetch_pkg;

   localparam int unsigned CPU5_OPCODE_SIZE = 7;
   localparam int unsigned CPU5_INSTR_WIDTH = 32;
   localparam int unsigned CPU5_ADDR_WIDTH  = 32;
   localparam logic [31:0] CPU5_RESET_PC    = 32'h0000_0000;

   function automatic logic [CPU5_OPCODE_SIZE-1:0] opcode_of(
      input logic [CPU5_INSTR_WIDTH-1:0] ins
   );
      return ins[CPU5_OPCODE_SIZE-1:0];
   endfunction

endpackage

// File: rtl/cpu5_ifetch_fifo.sv
// Small synchronous FIFO with flush.
// The head entry is read straight from storage.
module cpu5_ifetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
   end

   // The upstream credit scheme must never let a write land on a full buffer.
   push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/cpu5_ifetch.sv
// cpu5 instruction fetch: PC, request credits, stale-response dropping and
// the instruction buffer that feeds decode.
module cpu5_ifetch
   import cpu5_ifetch_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = CPU5_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(CPU5_RESET_PC),
   parameter int unsigned           DEPTH      = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic                        imem_req_valid,
   input  logic                        imem_req_ready,
   output logic [ADDR_WIDTH-1:0]       imem_addr,
   input  logic                        imem_rsp_valid,
   input  logic [CPU5_INSTR_WIDTH-1:0] imem_rsp_data,
   input  logic                        redirect_valid,
   input  logic [ADDR_WIDTH-1:0]       redirect_pc,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [CPU5_INSTR_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0]       instr_pc,
   output logic [CPU5_OPCODE_SIZE-1:0] dec_op
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = ADDR_WIDTH + CPU5_INSTR_WIDTH;

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] rsp_pc;
   logic [ADDR_WIDTH-1:0] target_pc;
   logic [CW-1:0]         inflight;
   logic [CW-1:0]         drop;
   logic [CW-1:0]         count;
   logic [CW:0]           credit_used;
   logic                  req_fire;
   logic                  rsp_fire;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [EW-1:0]         wdata;
   logic [EW-1:0]         rdata;

   assign target_pc   = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign credit_used = {1'b0, count} + {1'b0, inflight};

   // Buffered plus in-flight fetches never exceed the buffer size, so every
   // response always has a slot to land in.
   assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW + 1)'(DEPTH));
   assign imem_addr      = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_fire       = imem_rsp_valid && (inflight != '0);
   assign push           = rsp_fire && !redirect_valid && (drop == '0) && !reset;
   assign wdata          = {rsp_pc, imem_rsp_data};

   assign instr_valid      = !empty;
   assign pop              = instr_valid && instr_ready;
   assign {instr_pc, instr} = rdata;
   assign dec_op           = opcode_of(instr);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
         if (redirect_valid) begin
            pc     <= target_pc;
            rsp_pc <= target_pc;
            // Everything still outstanding after this cycle belongs to the old stream.
            drop   <= inflight - CW'(rsp_fire);
         end else begin
            if (req_fire) pc <= pc + ADDR_WIDTH'(4);
            if (rsp_fire) begin
               if (drop != '0) drop <= drop - CW'(1);
               else            rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
            end
         end
      end
   end

   cpu5_ifetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

endmodule

// File: tb/tb_cpu5_ifetch.sv
// Randomized scoreboard bench for cpu5_ifetch with an in-order memory model.
module tb_cpu5_ifetch;
   import cpu5_ifetch_pkg::*;

   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  dec_op;

   cpu5_ifetch #(
      .ADDR_WIDTH (AW),
      .RESET_PC   (RPC),
      .DEPTH      (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .dec_op         (dec_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          due;
      bit          live;
   } mem_item_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   mem_item_t   mem_q[$];   // accepted requests awaiting a response
   exp_t        out_q[$];   // instructions decode should see, in order
   logic [31:0] model_pc;
   int          cyc;
   int          max_lat;
   int          checks;
   int          errors;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_2083;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: settles the cycle's handshakes against the model at the falling edge.
   mem_item_t m;
   int        occ;
   int        mem_pre;
   bit        exp_rv;
   always @(negedge clk) begin
      if (reset) begin
         chk("req_valid_in_reset", 64'(imem_req_valid), 64'd0);
         mem_q.delete();
         out_q.delete();
         model_pc = RPC;
      end else begin
         mem_pre = mem_q.size();
         occ     = out_q.size() + mem_pre;
         exp_rv  = !redirect_valid && (occ < DEPTH);
         chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
         if (imem_req_valid) begin
            chk("imem_addr", 64'(imem_addr), 64'(model_pc));
            if (imem_req_ready) begin
               m.addr = model_pc;
               m.data = mem_data(model_pc);
               m.due  = cyc + $urandom_range(1, max_lat);
               m.live = 1'b1;
               mem_q.push_back(m);
               model_pc = model_pc + 32'd4;
            end
         end
         chk("instr_valid", 64'(instr_valid), 64'(out_q.size() > 0));
         if (instr_valid && out_q.size() > 0) begin
            chk("instr_pc", 64'(instr_pc), 64'(out_q[0].pc));
            chk("instr", 64'(instr), 64'(out_q[0].data));
            chk("dec_op", 64'(dec_op), 64'(out_q[0].data[6:0]));
            if (out_q[0].pc == 32'h0) chk("dec_op_at_0", 64'(dec_op), 64'(7'b0000011));
            if (instr_ready) void'(out_q.pop_front());
         end
         if (imem_rsp_valid && mem_pre > 0) begin
            m = mem_q.pop_front();
            if (m.live && !redirect_valid) out_q.push_back('{pc: m.addr, data: m.data});
         end
         if (redirect_valid) begin
            out_q.delete();
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            model_pc = {redirect_pc[31:2], 2'b00};
         end
      end
   end

   // Memory side: present the oldest pending response once its latency has elapsed.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q[0].data;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   bit hit;

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      max_lat = 1;
      model_pc = RPC;
      reset = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b1;

      repeat (2) tick();
      reset = 1'b0;

      // Free-running sequential fetch.
      repeat (20) tick();

      // Decode stall then release.
      instr_ready = 1'b0;
      repeat (10) tick();
      instr_ready = 1'b1;
      repeat (10) tick();

      // Redirect with the full credit in flight.
      max_lat = 4;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         tick();
         if (mem_q.size() == DEPTH) hit = 1'b1;
      end
      chk("inflight_full_reached", 64'(hit), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      max_lat = 1;
      repeat (15) tick();

      // Redirect coincident with a response, then a second redirect.
      max_lat = 2;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         tick();
         if (imem_rsp_valid) hit = 1'b1;
      end
      chk("rsp_for_redirect_seen", 64'(hit), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect_pc = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      repeat (15) tick();

      // Memory backpressure.
      imem_req_ready = 1'b0;
      repeat (3) tick();
      imem_req_ready = 1'b1;
      repeat (5) tick();

      // Randomized traffic with variable latency and occasional redirects.
      for (int i = 0; i < 400; i++) begin
         tick();
         imem_req_ready = ($urandom_range(0, 3) != 0);
         instr_ready = ($urandom_range(0, 3) != 0);
         max_lat = $urandom_range(1, 4);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc = $urandom;
      end
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      instr_ready = 1'b1;
      max_lat = 1;
      repeat (10) tick();

      // Reset with a full buffer.
      instr_ready = 1'b0;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      instr_ready = 1'b1;
      repeat (15) tick();

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      repeat (12) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
